// File: rtl/register_bank16.sv
// -----------------------------------------------------------------------------
// register_bank16
//
// Sixteen-entry register bank that sits directly in front of mux16. It has one
// synchronous write port and tracks a valid bit for each entry. It also runs a
// small scan sequencer that steps mux16's select through 0..15 once. This sweep
// serves the debug dump and checksum path.
//
// Parameters
//   N        data width of each entry (must match mux16 N)
//   ZERO_R0  1: entry 0 is hardwired to 0, writes to it are dropped and
//            valid[0] always reads 1
//
// Ports
//   clk         in   1     rising-edge clock
//   rst         in   1     synchronous active-high reset, beats every input
//   wr_ena      in   1     write strobe
//   wr_addr     in   4     write entry index
//   wr_data     in   N     write data
//   clr_all     in   1     clear all entries and valid bits next edge
//   scan_start  in   1     start a 16-step select sweep (ignored while busy)
//   q           out  16*N  packed entries, entry i at q[i*N +: N]
//   valid       out  16    valid[i]=1 once entry i written since reset/clear
//   scan_sel    out  4     mux16 select during a scan
//   scan_valid  out  1     scan_sel indexes a live scan step
//   scan_last   out  1     live step with scan_sel==15
//   busy        out  1     FSM is in SCAN; this is also the FSM state bit
//                          observed from outside (IDLE=0, SCAN=1)
//
// Handshake: there is no backpressure. A write is accepted on every rising
// edge where wr_ena=1 and neither rst nor clr_all is high. scan_start is
// accepted only on an edge where busy=0. After that edge scan_valid stays high
// for exactly 16 cycles, with scan_sel counting 0..15.
// -----------------------------------------------------------------------------
module register_bank16 #(
  parameter int N       = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  logic [3:0]      wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic            clr_all,
  input  logic            scan_start,
  output logic [16*N-1:0] q,
  output logic [15:0]     valid,
  output logic [3:0]      scan_sel,
  output logic            scan_valid,
  output logic            scan_last,
  output logic            busy
);

  // Bit 0 set when entry 0 is hardwired. It is removed from the write decode
  // and forced into the valid vector on reset and clear.
  localparam logic [15:0] R0_MASK = (ZERO_R0 != 0) ? 16'h0001 : 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [N-1:0] mem_q [16];
  logic [15:0]  valid_q;
  logic [15:0]  wr_sel_d;

  // One-hot write decode. At most one entry is enabled per edge.
  always_comb begin
    wr_sel_d = '0;
    if (wr_ena) begin
      wr_sel_d = (16'h0001 << wr_addr) & ~R0_MASK;
    end
  end

  // Priority on each edge: rst, then clr_all, then the write.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= R0_MASK;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wr_sel_d[i]) begin
          mem_q[i]   <= wr_data;
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  // Pack the entries for mux16. Entry 0 is tied to zero when hardwired, so it
  // never depends on the storage flops.
  always_comb begin
    q = '0;
    for (int i = 0; i < 16; i++) begin
      if ((ZERO_R0 != 0) && (i == 0)) begin
        q[i*N +: N] = '0;
      end else begin
        q[i*N +: N] = mem_q[i];
      end
    end
  end

  assign valid = valid_q;

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] scan_sel_q;
  logic       scan_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scan_sel_q   <= 4'd0;
      scan_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_start) begin
            state_q      <= SCAN;
            scan_sel_q   <= 4'd0;
            scan_valid_q <= 1'b1;
          end
        end
        SCAN: begin
          // scan_start is deliberately not looked at here, so a sweep in
          // progress cannot restart. clr_all has no effect on the sweep.
          if (scan_sel_q == 4'd15) begin
            state_q      <= IDLE;
            scan_sel_q   <= 4'd0;
            scan_valid_q <= 1'b0;
          end else begin
            scan_sel_q <= scan_sel_q + 4'd1;
          end
        end
        default: begin
          state_q      <= IDLE;
          scan_sel_q   <= 4'd0;
          scan_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (state_q == SCAN);
  assign scan_sel   = scan_sel_q;
  assign scan_valid = scan_valid_q;
  assign scan_last  = (state_q == SCAN) && (scan_sel_q == 4'd15);

endmodule

// File: tb/tb_register_bank16.sv
module tb_register_bank16;

  localparam int N = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           wr_ena = 1'b0;
  logic [3:0]     wr_addr = '0;
  logic [N-1:0]   wr_data = '0;
  logic           clr_all = 1'b0;
  logic           scan_start = 1'b0;

  // dut_a: ZERO_R0=0, dut_b: ZERO_R0=1, both driven with the same inputs
  logic [16*N-1:0] a_q, b_q;
  logic [15:0]     a_valid, b_valid;
  logic [3:0]      a_scan_sel, b_scan_sel;
  logic            a_scan_valid, b_scan_valid;
  logic            a_scan_last, b_scan_last;
  logic            a_busy, b_busy;

  register_bank16 #(.N(N), .ZERO_R0(0)) dut_a (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_all(clr_all), .scan_start(scan_start), .q(a_q), .valid(a_valid),
    .scan_sel(a_scan_sel), .scan_valid(a_scan_valid), .scan_last(a_scan_last),
    .busy(a_busy)
  );

  register_bank16 #(.N(N), .ZERO_R0(1)) dut_b (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_all(clr_all), .scan_start(scan_start), .q(b_q), .valid(b_valid),
    .scan_sel(b_scan_sel), .scan_valid(b_scan_valid), .scan_last(b_scan_last),
    .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model: plain arrays of entries, a valid vector per DUT, and the
  // scan step as an integer (-1 when idle).
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_mem [2][16];
  logic [15:0]  m_valid [2];
  int           m_step = -1;
  logic [N-1:0] exp_q [$];

  function automatic logic [16*N-1:0] exp_bus(int d);
    logic [16*N-1:0] bus;
    bus = '0;
    for (int i = 0; i < 16; i++) bus[i*N +: N] = m_mem[d][i];
    return bus;
  endfunction

  // One rising edge. The model applies the inputs as they were at the edge.
  // Outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || clr_all) begin
        for (int i = 0; i < 16; i++) m_mem[d][i] = '0;
        m_valid[d] = (d == 1) ? 16'h0001 : 16'h0000;
      end else if (wr_ena && !(d == 1 && wr_addr == 4'd0)) begin
        m_mem[d][wr_addr] = wr_data;
        m_valid[d][wr_addr] = 1'b1;
      end
    end
    if (rst)                          m_step = -1;
    else if (m_step < 0 && scan_start) m_step = 0;
    else if (m_step == 15)            m_step = -1;
    else if (m_step >= 0)             m_step = m_step + 1;
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_ena = 1'b0; clr_all = 1'b0; scan_start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; wr_ena = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A; scan_start = 1'b1;
    tick(); tick();
    idle_inputs();
    checks++; if (a_q !== '0) begin failures++; $display("FAIL reset_a_q got=%h exp=0", a_q); end
    checks++; if (a_valid !== 16'h0000) begin failures++; $display("FAIL reset_a_valid got=%h exp=0000", a_valid); end
    checks++; if (b_valid !== 16'h0001) begin failures++; $display("FAIL reset_b_valid got=%h exp=0001", b_valid); end
    checks++; if (a_busy !== 1'b0 || a_scan_valid !== 1'b0 || a_scan_sel !== 4'd0 || a_scan_last !== 1'b0) begin
      failures++; $display("FAIL reset_a_scan busy=%b sv=%b sel=%0d last=%b exp=0,0,0,0", a_busy, a_scan_valid, a_scan_sel, a_scan_last);
    end
    checks++; if (b_busy !== 1'b0 || b_scan_valid !== 1'b0) begin
      failures++; $display("FAIL reset_b_scan busy=%b sv=%b exp=0,0", b_busy, b_scan_valid);
    end
  endtask

  task automatic test_single_write();
    wr_ena = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
    #1;
    // wr_data must not appear on q before the edge
    checks++; if (a_q[47:40] !== 8'h00) begin failures++; $display("FAIL write_no_readthrough got=%h exp=00", a_q[47:40]); end
    tick();
    wr_ena = 1'b0;
    checks++; if (a_q[47:40] !== 8'hA5) begin failures++; $display("FAIL write_a_entry5 got=%h exp=a5", a_q[47:40]); end
    checks++; if (a_valid !== 16'h0020) begin failures++; $display("FAIL write_a_valid got=%h exp=0020", a_valid); end
    checks++; if (b_valid !== 16'h0021) begin failures++; $display("FAIL write_b_valid got=%h exp=0021", b_valid); end
    checks++; if (a_q !== {{10{8'h00}}, 8'hA5, {5{8'h00}}}) begin failures++; $display("FAIL write_a_others got=%h", a_q); end
  endtask

  task automatic test_random_writes();
    for (int it = 0; it < 60; it++) begin
      wr_ena  = ($urandom_range(0, 3) != 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom);
      clr_all = ($urandom_range(0, 29) == 0);
      tick();
      checks++; if (a_q !== exp_bus(0)) begin failures++; $display("FAIL rand_a_q it=%0d got=%h exp=%h", it, a_q, exp_bus(0)); end
      checks++; if (b_q !== exp_bus(1)) begin failures++; $display("FAIL rand_b_q it=%0d got=%h exp=%h", it, b_q, exp_bus(1)); end
      checks++; if (a_valid !== m_valid[0] || b_valid !== m_valid[1]) begin
        failures++; $display("FAIL rand_valid it=%0d got=%h/%h exp=%h/%h", it, a_valid, b_valid, m_valid[0], m_valid[1]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_scan();
    for (int i = 0; i < 16; i++) begin
      wr_ena = 1'b1; wr_addr = 4'(i); wr_data = 8'(i * 17);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i * 17));
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++; if (a_scan_valid !== 1'b1 || a_busy !== 1'b1 || a_scan_sel !== 4'(k)) begin
        failures++; $display("FAIL scan_step k=%0d sv=%b busy=%b sel=%0d exp=1,1,%0d", k, a_scan_valid, a_busy, a_scan_sel, k);
      end
      checks++; if (a_scan_last !== (k == 15)) begin
        failures++; $display("FAIL scan_last k=%0d got=%b exp=%b", k, a_scan_last, (k == 15));
      end
      checks++; if (a_q[a_scan_sel*N +: N] !== exp_q[0]) begin
        failures++; $display("FAIL scan_mux_a k=%0d got=%h exp=%h", k, a_q[a_scan_sel*N +: N], exp_q[0]);
      end
      void'(exp_q.pop_front());
      checks++; if (b_q[b_scan_sel*N +: N] !== ((k == 0) ? 8'h00 : 8'(k * 17))) begin
        failures++; $display("FAIL scan_mux_b k=%0d got=%h", k, b_q[b_scan_sel*N +: N]);
      end
      tick();
    end
    checks++; if (a_busy !== 1'b0 || a_scan_valid !== 1'b0 || a_scan_sel !== 4'd0 || a_scan_last !== 1'b0) begin
      failures++; $display("FAIL scan_end busy=%b sv=%b sel=%0d last=%b exp=0,0,0,0", a_busy, a_scan_valid, a_scan_sel, a_scan_last);
    end
  endtask

  task automatic test_scan_with_writes();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      // mux output must show the entry as it is stored in the current cycle
      checks++; if (m_step < 0 || a_q[a_scan_sel*N +: N] !== m_mem[0][m_step] || a_scan_sel !== 4'(m_step)) begin
        failures++; $display("FAIL scanw_a k=%0d sel=%0d got=%h exp_step=%0d", k, a_scan_sel, a_q[a_scan_sel*N +: N], m_step);
      end
      wr_ena  = 1'b1;
      wr_addr = ($urandom_range(0, 1) != 0) ? 4'(k) : 4'($urandom_range(0, 15));
      wr_data = 8'($urandom);
      tick();
    end
    idle_inputs();
    checks++; if (a_busy !== 1'b0 || a_q !== exp_bus(0)) begin
      failures++; $display("FAIL scanw_end busy=%b q=%h exp=%h", a_busy, a_q, exp_bus(0));
    end
  endtask

  task automatic test_back_to_back();
    int sv_cycles;
    int budget;
    // wr_ena and clr_all on the same edge: the clear wins
    wr_ena = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C; clr_all = 1'b1;
    tick();
    idle_inputs();
    checks++; if (a_q !== '0 || a_valid !== 16'h0000) begin failures++; $display("FAIL clr_prio_a q=%h valid=%h exp=0,0000", a_q, a_valid); end
    checks++; if (b_q !== '0 || b_valid !== 16'h0001) begin failures++; $display("FAIL clr_prio_b q=%h valid=%h exp=0,0001", b_q, b_valid); end
    // Hold scan_start for several cycles while busy and clear mid-scan.
    // The sweep must neither restart nor stop.
    wr_ena = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
    tick();
    idle_inputs();
    scan_start = 1'b1;
    sv_cycles = 0;
    budget = 0;
    tick();
    while (a_scan_valid === 1'b1 && budget < 40) begin
      sv_cycles++;
      budget++;
      if (budget == 4) clr_all = 1'b1;
      if (budget == 5) begin clr_all = 1'b0; scan_start = 1'b0; end
      tick();
    end
    idle_inputs();
    checks++; if (sv_cycles !== 16) begin failures++; $display("FAIL busy_ignore_start sv_cycles=%0d exp=16", sv_cycles); end
    checks++; if (a_q !== '0 || a_valid !== 16'h0000 || a_busy !== 1'b0) begin
      failures++; $display("FAIL clr_during_scan q=%h valid=%h busy=%b", a_q, a_valid, a_busy);
    end
  endtask

  task automatic test_zero_r0();
    wr_ena = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    tick();
    idle_inputs();
    checks++; if (b_q[7:0] !== 8'h00 || b_valid[0] !== 1'b1) begin
      failures++; $display("FAIL zero_r0_b q0=%h v0=%b exp=00,1", b_q[7:0], b_valid[0]);
    end
    checks++; if (a_q[7:0] !== 8'hFF || a_valid[0] !== 1'b1) begin
      failures++; $display("FAIL zero_r0_a q0=%h v0=%b exp=ff,1", a_q[7:0], a_valid[0]);
    end
  endtask

  task automatic test_reset_mid_scan();
    wr_ena = 1'b1; wr_addr = 4'd7; wr_data = 8'h81;
    tick();
    idle_inputs();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (a_scan_sel !== 4'd7 || a_busy !== 1'b1) begin
      failures++; $display("FAIL midscan_pos sel=%0d busy=%b exp=7,1", a_scan_sel, a_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_scan_sel !== 4'd0 || a_scan_valid !== 1'b0 || a_scan_last !== 1'b0) begin
      failures++; $display("FAIL midscan_abort busy=%b sel=%0d sv=%b last=%b exp=0,0,0,0", a_busy, a_scan_sel, a_scan_valid, a_scan_last);
    end
    checks++; if (a_q !== '0 || a_valid !== 16'h0000 || b_valid !== 16'h0001) begin
      failures++; $display("FAIL midscan_data q=%h va=%h vb=%h", a_q, a_valid, b_valid);
    end
    tick();
    checks++; if (a_busy !== 1'b0 || a_scan_valid !== 1'b0) begin
      failures++; $display("FAIL midscan_stays_idle busy=%b sv=%b", a_busy, a_scan_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_mem[d][i] = '0;
      m_valid[d] = '0;
    end
    test_reset();
    test_single_write();
    test_random_writes();
    test_scan();
    test_scan_with_writes();
    test_back_to_back();
    test_zero_r0();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
